// File: rtl/sdram_emu.sv
// sdram_emu: block-RAM stand-in for the sdram_top request/ack interface.
// Holds 2^AW 16-bit words with byte-enabled writes and a fixed read latency.
// Address bits above AW-1 are ignored, so the space aliases every 2^AW words.
// Optional refresh emulation is compiled in with `define SDRAM_EMU_REFRESH_EN.
// In that build a REFRESH demand fires every REF_PERIOD clocks after init.
// The demand is honoured only in IDLE and stalls the port for 8 clocks.

module sdram_emu #(
    parameter int unsigned AW          = 14,
    parameter int unsigned INIT_CYCLES = 100,
    parameter int unsigned RD_LAT      = 3,
    parameter int unsigned REF_PERIOD  = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_wr_req,
    input  logic        sdram_rd_req,
    output logic        sdram_wr_ack,
    output logic        sdram_rd_ack,
    input  logic [1:0]  sdram_byteenable,
    input  logic [21:0] sys_wraddr,
    input  logic [21:0] sys_rdaddr,
    input  logic [15:0] sys_data_in,
    output logic [15:0] sys_data_out,
    output logic        sdram_init_done
);

    // Shared counter: init, read latency and refresh hold.
    // It is at least 4 bits so any legal RD_LAT fits without wrapping.
    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
    localparam int unsigned CW = (IW > 4) ? IW : 4;

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT);
    localparam logic [CW-1:0] RD_PRE    = CW'(RD_LAT - 1);
    localparam int unsigned   DEPTH     = 1 << AW;

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("sdram_emu: RD_LAT must be in 1..15");
    end

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StWrite,
        StRead,
        StRelease
`ifdef SDRAM_EMU_REFRESH_EN
        , StRefresh
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    logic [AW-1:0]   rd_addr_q;
    logic            accept_rd;
    logic            load_out;
    logic [AW-1:0]   rd_sel;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     mem [0:DEPTH-1];

    // Upper address bits are deliberately not decoded.
    if (AW < 22) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^{sys_wraddr[21:AW], sys_rdaddr[21:AW]};
    end

    assign wr_addr = sys_wraddr[AW-1:0];

`ifdef SDRAM_EMU_REFRESH_EN
    localparam int unsigned   RW       = ($clog2(REF_PERIOD + 1) > 1) ? $clog2(REF_PERIOD + 1) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REF_PERIOD - 1);

    logic [RW-1:0] ref_cnt_q;
    logic          ref_pend_q;
    logic          ref_fire;
    logic          ref_take;

    assign ref_fire = init_done_q && (ref_cnt_q == REF_LAST);

    // Free-running refresh timer; at most one demand is ever pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else if (init_done_q) begin
            ref_cnt_q  <= ref_fire ? '0 : ref_cnt_q + RW'(1);
            ref_pend_q <= ref_fire | (ref_pend_q & ~ref_take);
        end
    end
`else
    logic [31:0] unused_ref_period;
    assign unused_ref_period = REF_PERIOD;
`endif

    // State register, shared counter and sticky init flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic; write wins over read, and refresh wins over both.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        accept_rd   = 1'b0;
`ifdef SDRAM_EMU_REFRESH_EN
        ref_take    = 1'b0;
`endif
        unique case (state_q)
            StInit: begin
                if (cnt_q == INIT_LAST) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StIdle: begin
`ifdef SDRAM_EMU_REFRESH_EN
                if (ref_pend_q) begin
                    state_d  = StRefresh;
                    cnt_d    = '0;
                    ref_take = 1'b1;
                end else
`endif
                if (sdram_wr_req) begin
                    state_d = StWrite;
                end else if (sdram_rd_req) begin
                    // Counter is 1 in the first READ cycle so the ack lands at T+RD_LAT.
                    state_d   = StRead;
                    cnt_d     = CW'(1);
                    accept_rd = 1'b1;
                end
            end
            StWrite: begin
                state_d = StRelease;
            end
            StRead: begin
                if (cnt_q == RD_LAST) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRelease: begin
                // Wait for both levels to drop so a held request is served once.
                if (!sdram_wr_req && !sdram_rd_req) begin
                    state_d = StIdle;
                end
            end
`ifdef SDRAM_EMU_REFRESH_EN
            StRefresh: begin
                if (cnt_q == CW'(7)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore acks plus the strobe that loads read data for the ack cycle.
    always_comb begin
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        load_out     = 1'b0;
        rd_sel       = rd_addr_q;
        if (state_q == StWrite) begin
            sdram_wr_ack = 1'b1;
        end
        if (state_q == StRead && cnt_q == RD_LAST) begin
            sdram_rd_ack = 1'b1;
        end
        if (accept_rd) begin
            rd_sel = sys_rdaddr[AW-1:0];
        end
        // Load on the edge entering the ack cycle; with RD_LAT=1 that is acceptance.
        if ((accept_rd && RD_LAT == 1) ||
            (state_q == StRead && cnt_q == RD_PRE && cnt_q != RD_LAST)) begin
            load_out = 1'b1;
        end
    end

    assign sdram_init_done = init_done_q;

    // Read address is captured once, at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
        end else if (accept_rd) begin
            rd_addr_q <= sys_rdaddr[AW-1:0];
        end
    end

    // Read data register holds its value until the next read ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_data_out <= 16'h0000;
        end else if (load_out) begin
            sys_data_out <= mem[rd_sel];
        end
    end

    // RAM array is never reset; a write lands at the edge closing the WRITE cycle.
    always_ff @(posedge clk) begin
        if (state_q == StWrite) begin
            if (sdram_byteenable[0]) begin
                mem[wr_addr][7:0] <= sys_data_in[7:0];
            end
            if (sdram_byteenable[1]) begin
                mem[wr_addr][15:8] <= sys_data_in[15:8];
            end
        end
    end

endmodule
